// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx
//   Receives the PS/2 keyboard serial stream and delivers decoded scancodes
//   to the keyboard matrix logic. Both pins are synchronised into the CLK
//   domain. PS2_CLK is deglitched and treated purely as data. 11-bit frames
//   (start, 8 data LSB-first, parity, stop) are deserialised. E0/F0 prefixes
//   are folded into flags, so each key event gives exactly one KEY_VALID.
//
//   Ports:
//     CLK          system clock (CLK100MHZ domain)
//     RESET        synchronous, active-high reset
//     PS2_CLK      raw keyboard clock pin (asynchronous)
//     PS2_DATA     raw keyboard data pin (asynchronous)
//     KEY_CODE     last completed scancode, prefixes stripped
//     KEY_EXTENDED KEY_CODE was preceded by E0
//     KEY_RELEASE  KEY_CODE was preceded by F0
//     KEY_VALID    one-cycle strobe; KEY_CODE and the flags are valid now
//     FRAME_ERR    one-cycle strobe: bad start bit, bad stop bit or timeout
//     PARITY_ERR   one-cycle strobe: odd-parity failure
//
//   Handshake: KEY_VALID, FRAME_ERR and PARITY_ERR are valid-only strobes.
//   There is no ready/backpressure. A consumer must take KEY_CODE and the
//   flags in the cycle KEY_VALID is high. They then hold until the next
//   KEY_VALID. At most one strobe is high in any cycle.
//
//   Optional feature (macro PS2_PARITY_CHECK_EN): when defined, odd parity is
//   checked at the stop bit. A failure raises PARITY_ERR instead of
//   KEY_VALID. When undefined, the parity bit is ignored and PARITY_ERR
//   is tied to 0.

module ps2_keyboard_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic [7:0] KEY_CODE,
    output logic       KEY_EXTENDED,
    output logic       KEY_RELEASE,
    output logic       KEY_VALID,
    output logic       FRAME_ERR,
    output logic       PARITY_ERR
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t         state;
    logic           clk_s1, clk_s2, data_s1, data_s2;
    logic           clk_filt, clk_filt_d;
    logic [FW-1:0]  filt_cnt;
    logic [TW-1:0]  to_cnt;
    logic [2:0]     bit_cnt;
    logic [7:0]     shift_reg;
    logic           ext_flag, rel_flag;
    logic           ps2_fall;
`ifdef PS2_PARITY_CHECK_EN
    logic           parity_bit;
`endif

    // Two-flop synchronisers; idle level of both pins is high.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
        end else begin
            clk_s1  <= PS2_CLK;
            clk_s2  <= clk_s1;
            data_s1 <= PS2_DATA;
            data_s2 <= data_s1;
        end
    end

    // Deglitch filter. The filtered clock flips on the FILTER_LEN-th
    // consecutive disagreeing sample. Any agreeing sample restarts the count.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            clk_filt   <= 1'b1;
            clk_filt_d <= 1'b1;
            filt_cnt   <= '0;
        end else begin
            clk_filt_d <= clk_filt;
            if (clk_s2 != clk_filt) begin
                if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                    clk_filt <= ~clk_filt;
                    filt_cnt <= '0;
                end else begin
                    filt_cnt <= filt_cnt + 1'b1;
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    // Sample point: data_s2 is taken in the cycle this is high.
    assign ps2_fall = clk_filt_d & ~clk_filt;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            to_cnt       <= '0;
            ext_flag     <= 1'b0;
            rel_flag     <= 1'b0;
            KEY_CODE     <= '0;
            KEY_EXTENDED <= 1'b0;
            KEY_RELEASE  <= 1'b0;
            KEY_VALID    <= 1'b0;
            FRAME_ERR    <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            parity_bit   <= 1'b0;
            PARITY_ERR   <= 1'b0;
`endif
        end else begin
            KEY_VALID <= 1'b0;
            FRAME_ERR <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            PARITY_ERR <= 1'b0;
`endif
            // Idle-time watchdog: only runs while a frame is in progress.
            if (state == IDLE || ps2_fall) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end

            if (state != IDLE && !ps2_fall && to_cnt == TW'(TIMEOUT_CYCLES)) begin
                FRAME_ERR <= 1'b1;
                state     <= IDLE;
                to_cnt    <= '0;
                ext_flag  <= 1'b0;
                rel_flag  <= 1'b0;
            end else if (ps2_fall) begin
                case (state)
                    IDLE: begin
                        if (!data_s2) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end else begin
                            // Start bit must be 0.
                            FRAME_ERR <= 1'b1;
                            ext_flag  <= 1'b0;
                            rel_flag  <= 1'b0;
                        end
                    end
                    DATA: begin
                        shift_reg[bit_cnt] <= data_s2;
                        bit_cnt            <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                        parity_bit <= data_s2;
`endif
                        state <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (data_s2) begin
`ifdef PS2_PARITY_CHECK_EN
                            if (^{shift_reg, parity_bit} == 1'b0) begin
                                PARITY_ERR <= 1'b1;
                                ext_flag   <= 1'b0;
                                rel_flag   <= 1'b0;
                            end else
`endif
                            if (shift_reg == 8'hE0) begin
                                ext_flag <= 1'b1;
                            end else if (shift_reg == 8'hF0) begin
                                rel_flag <= 1'b1;
                            end else begin
                                KEY_CODE     <= shift_reg;
                                KEY_EXTENDED <= ext_flag;
                                KEY_RELEASE  <= rel_flag;
                                KEY_VALID    <= 1'b1;
                                ext_flag     <= 1'b0;
                                rel_flag     <= 1'b0;
                            end
                        end else begin
                            // Stop bit must be 1; drop the frame.
                            FRAME_ERR <= 1'b1;
                            ext_flag  <= 1'b0;
                            rel_flag  <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifndef PS2_PARITY_CHECK_EN
    assign PARITY_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
module tb_ps2_keyboard_rx;

  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 200;
  localparam int HALF           = 32;   // half PS/2 clock period in CLK cycles
  localparam int DATA_DLY       = 16;   // data changes this long after the rise
  localparam int LATENCY        = 11;   // raw stop fall drive -> KEY_VALID seen
  localparam int IDLE_GAP       = 100;

  localparam logic [1:0] EV_KEY    = 2'd0;
  localparam logic [1:0] EV_FRAME  = 2'd1;
  localparam logic [1:0] EV_PARITY = 2'd2;

  logic       CLK;
  logic       RESET;
  logic       PS2_CLK;
  logic       PS2_DATA;
  logic [7:0] KEY_CODE;
  logic       KEY_EXTENDED;
  logic       KEY_RELEASE;
  logic       KEY_VALID;
  logic       FRAME_ERR;
  logic       PARITY_ERR;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stop_fall_cyc = 0;
  logic [11:0] exp_q[$];

  ps2_keyboard_rx #(
    .FILTER_LEN(FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .PS2_CLK(PS2_CLK),
    .PS2_DATA(PS2_DATA),
    .KEY_CODE(KEY_CODE),
    .KEY_EXTENDED(KEY_EXTENDED),
    .KEY_RELEASE(KEY_RELEASE),
    .KEY_VALID(KEY_VALID),
    .FRAME_ERR(FRAME_ERR),
    .PARITY_ERR(PARITY_ERR)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  function automatic logic odd_par(input logic [7:0] b);
    return ~^b;
  endfunction

  // Drive bits[0] first. One PS/2 clock period per bit.
  // With glitch set, a FILTER_LEN-1 cycle low pulse is put on PS2_CLK
  // during the high phase of bit 4.
  task automatic send_bits(input logic [10:0] bits, input int nbits, input bit glitch);
    for (int i = 0; i < nbits; i++) begin
      wait_cycles(DATA_DLY);
      PS2_DATA = bits[i];
      if (glitch && i == 4) begin
        wait_cycles(2);
        PS2_CLK = 1'b0;
        wait_cycles(FILTER_LEN - 1);
        PS2_CLK = 1'b1;
        wait_cycles(HALF - DATA_DLY - 2 - (FILTER_LEN - 1));
      end else begin
        wait_cycles(HALF - DATA_DLY);
      end
      PS2_CLK = 1'b0;
      if (i == nbits - 1) stop_fall_cyc = cyc;
      wait_cycles(HALF);
      PS2_CLK = 1'b1;
    end
    PS2_DATA = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop, input bit glitch);
    send_bits({stop, par, b, 1'b0}, 11, glitch);
    wait_cycles(IDLE_GAP);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, odd_par(b), 1'b1, 1'b0);
  endtask

  task automatic push_key(input logic [7:0] code, input logic ext, input logic rel);
    exp_q.push_back({EV_KEY, ext, rel, code});
  endtask

  task automatic push_err(input logic [1:0] kind);
    exp_q.push_back({kind, 10'd0});
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if ({KEY_CODE, KEY_EXTENDED, KEY_RELEASE, KEY_VALID, FRAME_ERR, PARITY_ERR} !== 13'd0) begin
      errors++;
      $display("FAIL %s: outputs=%h required=0", name,
               {KEY_CODE, KEY_EXTENDED, KEY_RELEASE, KEY_VALID, FRAME_ERR, PARITY_ERR});
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge CLK) begin
    int n;
    logic [11:0] act;
    logic [11:0] e;
    if (!RESET) begin
      n = int'(KEY_VALID) + int'(FRAME_ERR) + int'(PARITY_ERR);
      if (n > 0) begin
        checks++;
        if (n != 1) begin
          errors++;
          $display("FAIL one_strobe: %0d strobes high, required 1", n);
        end
        if (KEY_VALID)      act = {EV_KEY, KEY_EXTENDED, KEY_RELEASE, KEY_CODE};
        else if (FRAME_ERR) act = {EV_FRAME, 10'd0};
        else                act = {EV_PARITY, 10'd0};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: got %h, queue empty", act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            errors++;
            $display("FAIL event: got %h required %h", act, e);
          end
        end
        if (KEY_VALID) begin
          checks++;
          if (cyc - stop_fall_cyc != LATENCY) begin
            errors++;
            $display("FAIL latency: got %0d required %0d", cyc - stop_fall_cyc, LATENCY);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    PS2_CLK  = 1'b1;
    PS2_DATA = 1'b1;
    RESET    = 1'b1;
    wait_cycles(5);
    check_idle_outputs("reset_outputs");
    RESET = 1'b0;
    wait_cycles(20);
    check_idle_outputs("post_reset_outputs");

    // Plain make code
    push_key(8'h12, 1'b0, 1'b0);
    send_byte(8'h12);

    // Break code, then a plain byte with release cleared
    push_key(8'h55, 1'b0, 1'b1);
    send_byte(8'hF0);
    send_byte(8'h55);
    push_key(8'h23, 1'b0, 1'b0);
    send_byte(8'h23);

    // Both prefix orders give both flags set
    push_key(8'h75, 1'b1, 1'b1);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    push_key(8'h6B, 1'b1, 1'b1);
    send_byte(8'hF0);
    send_byte(8'hE0);
    send_byte(8'h6B);

    // Extended only
    push_key(8'h70, 1'b1, 1'b0);
    send_byte(8'hE0);
    send_byte(8'h70);

    // Timeout mid-frame with a pending F0: error, and the flag is cleared
    send_byte(8'hF0);
    push_err(EV_FRAME);
    send_bits({1'b1, odd_par(8'h1C), 8'h1C, 1'b0}, 5, 1'b0);
    wait_cycles(TIMEOUT_CYCLES + 10);
    push_key(8'h1C, 1'b0, 1'b0);
    send_byte(8'h1C);

    // Bad stop bit with a pending E0
    send_byte(8'hE0);
    push_err(EV_FRAME);
    send_frame(8'h29, odd_par(8'h29), 1'b0, 1'b0);
    checks++;
    if (KEY_CODE !== 8'h1C) begin
      errors++;
      $display("FAIL key_code_hold: got %h required 1c", KEY_CODE);
    end
    push_key(8'h29, 1'b0, 1'b0);
    send_byte(8'h29);

    // Glitch of FILTER_LEN-1 cycles mid-frame must be ignored
    push_key(8'h4D, 1'b0, 1'b0);
    send_frame(8'h4D, odd_par(8'h4D), 1'b1, 1'b1);

    // Start bit of 1 in IDLE
    push_err(EV_FRAME);
    send_bits(11'h7FF, 1, 1'b0);
    wait_cycles(IDLE_GAP);
    push_key(8'h5A, 1'b0, 1'b0);
    send_byte(8'h5A);

    // Parity handling
`ifdef PS2_PARITY_CHECK_EN
    push_key(8'h12, 1'b0, 1'b0);
    send_frame(8'h12, 1'b1, 1'b1, 1'b0);
    send_byte(8'hF0);
    push_err(EV_PARITY);
    send_frame(8'h12, 1'b0, 1'b1, 1'b0);
    push_key(8'h12, 1'b0, 1'b0);
    send_frame(8'h12, 1'b1, 1'b1, 1'b0);
`else
    send_byte(8'hF0);
    push_key(8'h12, 1'b0, 1'b1);
    send_frame(8'h12, 1'b0, 1'b1, 1'b0);
`endif

    wait_cycles(200);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events: %0d expected events never seen, required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
